pingpong_merger: RTL and testbench

Downstream counterpart of the ping-pong splitter. It takes the two AXI-Stream paths leaving the splitter, usually after per-path processing, and re-interleaves them into one stream. It takes PP_GROUP complete packets from path 1, then PP_GROUP complete packets from path 2, and repeats. A registered output skid slice gives full throughput with no combinational ready path from output to inputs.

---
 rtl/pingpong_pkg.sv | 18 +
 rtl/pingpong_merger_axis_skid_slice.sv | 65 ++++++
 rtl/pingpong_merger.sv | 113 +++++++++++
 tb/tb_pingpong_merger.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pingpong_pkg.sv
// Definitions shared by the ping-pong splitter and merger so both sides agree on path numbering.
package pingpong_pkg;

    localparam logic SEL1 = 1'b0;
    localparam logic SEL2 = 1'b1;
    localparam int DEFAULT_DW = 512;

    typedef enum logic {
        ST_SEL1 = SEL1,
        ST_SEL2 = SEL2
    } pp_state_t;

    // A group size of zero would never end a group, so it is promoted to one.
    function automatic logic [31:0] group_limit(input logic [31:0] pp_group);
        return (pp_group == 32'd0) ? 32'd1 : pp_group;
    endfunction

endpackage

// File: rtl/pingpong_merger_axis_skid_slice.sv
// Two-entry registered AXI-Stream slice: an output register plus one skid entry,
// so the upstream ready is a flop and never depends combinationally on m_tready.
module axis_skid_slice #(
    parameter int DW = 512
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [DW-1:0]   s_tdata,
    input  logic [DW/8-1:0] s_tkeep,
    input  logic            s_tlast,
    input  logic            s_tvalid,
    output logic            s_tready,
    output logic [DW-1:0]   m_tdata,
    output logic [DW/8-1:0] m_tkeep,
    output logic            m_tlast,
    output logic            m_tvalid,
    input  logic            m_tready
);

    logic [DW-1:0]   sk_data;
    logic [DW/8-1:0] sk_keep;
    logic            sk_last;
    logic            sk_valid;
    logic            s_fire;

    assign s_fire = s_tvalid && s_tready;

    // s_tready tracks "skid entry empty" one edge late, and is held low through reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
            m_tvalid <= 1'b0;
            sk_data  <= '0;
            sk_keep  <= '0;
            sk_last  <= 1'b0;
            sk_valid <= 1'b0;
            s_tready <= 1'b0;
        end else if (!m_tvalid || m_tready) begin
            if (sk_valid) begin
                m_tdata  <= sk_data;
                m_tkeep  <= sk_keep;
                m_tlast  <= sk_last;
                m_tvalid <= 1'b1;
                sk_valid <= 1'b0;
            end else begin
                m_tvalid <= s_fire;
                if (s_fire) begin
                    m_tdata <= s_tdata;
                    m_tkeep <= s_tkeep;
                    m_tlast <= s_tlast;
                end
            end
            s_tready <= 1'b1;
        end else if (s_fire) begin
            sk_data  <= s_tdata;
            sk_keep  <= s_tkeep;
            sk_last  <= s_tlast;
            sk_valid <= 1'b1;
            s_tready <= 1'b0;
        end
    end

endmodule

// File: rtl/pingpong_merger.sv
// Re-interleaves the two ping-pong paths: PP_GROUP whole packets from path 1, then from path 2,
// switching only on packet boundaries, through a registered skid slice.
module pingpong_merger
    import pingpong_pkg::*;
#(
    parameter int DW = DEFAULT_DW
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [31:0]     PP_GROUP,
    input  logic [DW-1:0]   AXIS_IN1_TDATA,
    input  logic [DW/8-1:0] AXIS_IN1_TKEEP,
    input  logic            AXIS_IN1_TLAST,
    input  logic            AXIS_IN1_TVALID,
    output logic            AXIS_IN1_TREADY,
    input  logic [DW-1:0]   AXIS_IN2_TDATA,
    input  logic [DW/8-1:0] AXIS_IN2_TKEEP,
    input  logic            AXIS_IN2_TLAST,
    input  logic            AXIS_IN2_TVALID,
    output logic            AXIS_IN2_TREADY,
    output logic [DW-1:0]   AXIS_OUT_TDATA,
    output logic [DW/8-1:0] AXIS_OUT_TKEEP,
    output logic            AXIS_OUT_TLAST,
    output logic            AXIS_OUT_TVALID,
    input  logic            AXIS_OUT_TREADY,
    output logic            sel,
    output logic [31:0]     pkt_count
);

    pp_state_t       state;
    pp_state_t       state_next;
    logic [31:0]     grp_cnt;
    logic [31:0]     grp_lim;
    logic            slice_in_ready;
    logic            in_valid;
    logic            in_last;
    logic [DW-1:0]   in_data;
    logic [DW/8-1:0] in_keep;
    logic            in_fire;
    logic            last_fire;
    logic            group_end;

    always_comb begin
        in_valid = AXIS_IN1_TVALID;
        in_data  = AXIS_IN1_TDATA;
        in_keep  = AXIS_IN1_TKEEP;
        in_last  = AXIS_IN1_TLAST;
        if (state == ST_SEL2) begin
            in_valid = AXIS_IN2_TVALID;
            in_data  = AXIS_IN2_TDATA;
            in_keep  = AXIS_IN2_TKEEP;
            in_last  = AXIS_IN2_TLAST;
        end
    end

    assign AXIS_IN1_TREADY = (state == ST_SEL1) && slice_in_ready;
    assign AXIS_IN2_TREADY = (state == ST_SEL2) && slice_in_ready;
    assign in_fire         = in_valid && slice_in_ready;
    assign last_fire       = in_fire && in_last;
    assign group_end       = last_fire && (grp_cnt == grp_lim - 32'd1);
    assign sel             = state;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_SEL1;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (group_end) begin
            state_next = (state == ST_SEL1) ? ST_SEL2 : ST_SEL1;
        end
    end

    // grp_lim is reloaded only while in reset and at a group switch, so a PP_GROUP
    // change lands on the next group boundary rather than mid-group.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            grp_cnt   <= 32'd0;
            grp_lim   <= group_limit(PP_GROUP);
            pkt_count <= 32'd0;
        end else if (last_fire) begin
            pkt_count <= pkt_count + 32'd1;
            if (group_end) begin
                grp_cnt <= 32'd0;
                grp_lim <= group_limit(PP_GROUP);
            end else begin
                grp_cnt <= grp_cnt + 32'd1;
            end
        end
    end

    axis_skid_slice #(
        .DW(DW)
    ) u_slice (
        .clk      (clk),
        .resetn   (resetn),
        .s_tdata  (in_data),
        .s_tkeep  (in_keep),
        .s_tlast  (in_last),
        .s_tvalid (in_valid),
        .s_tready (slice_in_ready),
        .m_tdata  (AXIS_OUT_TDATA),
        .m_tkeep  (AXIS_OUT_TKEEP),
        .m_tlast  (AXIS_OUT_TLAST),
        .m_tvalid (AXIS_OUT_TVALID),
        .m_tready (AXIS_OUT_TREADY)
    );

endmodule

// File: tb/tb_pingpong_merger.sv
// Bench for pingpong_merger: a cycle table for handshake/reset behaviour, then packet streams
// compared against a packet-level interleave model, with optional random backpressure.
module tb_pingpong_merger;

    localparam int DW = 512;
    localparam int KW = DW / 8;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct {
        logic        rstn, v1, v2, ordy;
        logic        e_r1, e_r2, e_ov, e_sel;
        logic [31:0] e_pc;
    } vec_t;

    logic          clk;
    logic          resetn;
    logic [31:0]   PP_GROUP;
    logic [DW-1:0] AXIS_IN1_TDATA;
    logic [KW-1:0] AXIS_IN1_TKEEP;
    logic          AXIS_IN1_TLAST;
    logic          AXIS_IN1_TVALID;
    logic          AXIS_IN1_TREADY;
    logic [DW-1:0] AXIS_IN2_TDATA;
    logic [KW-1:0] AXIS_IN2_TKEEP;
    logic          AXIS_IN2_TLAST;
    logic          AXIS_IN2_TVALID;
    logic          AXIS_IN2_TREADY;
    logic [DW-1:0] AXIS_OUT_TDATA;
    logic [KW-1:0] AXIS_OUT_TKEEP;
    logic          AXIS_OUT_TLAST;
    logic          AXIS_OUT_TVALID;
    logic          AXIS_OUT_TREADY;
    logic          sel;
    logic [31:0]   pkt_count;

    int    checks = 0;
    int    failures = 0;
    beat_t src1[$];
    beat_t src2[$];
    beat_t exp_q[$];
    beat_t out_q[$];
    int    out_cyc[$];
    int    i1, i2, cycle, pkt_id;
    int    hs1_last_cyc, hs2_first_cyc;
    int    pp_switch_beat;
    logic [31:0] pp_switch_val;
    bit    p1_en, rdy_rand, rst_chk;
    bit    prev_stall, last_edge_rst;
    bit    samp_in2_ready, samp_ov;
    beat_t prev_beat;
    vec_t  tbl[12];

    pingpong_merger #(.DW(DW)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .PP_GROUP        (PP_GROUP),
        .AXIS_IN1_TDATA  (AXIS_IN1_TDATA),
        .AXIS_IN1_TKEEP  (AXIS_IN1_TKEEP),
        .AXIS_IN1_TLAST  (AXIS_IN1_TLAST),
        .AXIS_IN1_TVALID (AXIS_IN1_TVALID),
        .AXIS_IN1_TREADY (AXIS_IN1_TREADY),
        .AXIS_IN2_TDATA  (AXIS_IN2_TDATA),
        .AXIS_IN2_TKEEP  (AXIS_IN2_TKEEP),
        .AXIS_IN2_TLAST  (AXIS_IN2_TLAST),
        .AXIS_IN2_TVALID (AXIS_IN2_TVALID),
        .AXIS_IN2_TREADY (AXIS_IN2_TREADY),
        .AXIS_OUT_TDATA  (AXIS_OUT_TDATA),
        .AXIS_OUT_TKEEP  (AXIS_OUT_TKEEP),
        .AXIS_OUT_TLAST  (AXIS_OUT_TLAST),
        .AXIS_OUT_TVALID (AXIS_OUT_TVALID),
        .AXIS_OUT_TREADY (AXIS_OUT_TREADY),
        .sel             (sel),
        .pkt_count       (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit beat_eq(input beat_t a, input beat_t b);
        return (a.data === b.data) && (a.keep === b.keep) && (a.last === b.last);
    endfunction

    task automatic check_beat(input string name, input beat_t act, input beat_t exp);
        checks++;
        if (!beat_eq(act, exp)) begin
            failures++;
            $display("[TB] FAIL %s: got data[63:0]=0x%016h keep=0x%016h last=%0b, expected data[63:0]=0x%016h keep=0x%016h last=%0b",
                     name, act.data[63:0], act.keep, act.last, exp.data[63:0], exp.keep, exp.last);
        end
    endtask

    task automatic drive_inputs();
        if (p1_en && i1 < src1.size()) begin
            AXIS_IN1_TVALID = 1'b1;
            AXIS_IN1_TDATA  = src1[i1].data;
            AXIS_IN1_TKEEP  = src1[i1].keep;
            AXIS_IN1_TLAST  = src1[i1].last;
        end else begin
            AXIS_IN1_TVALID = 1'b0;
            AXIS_IN1_TDATA  = '0;
            AXIS_IN1_TKEEP  = '0;
            AXIS_IN1_TLAST  = 1'b0;
        end
        if (i2 < src2.size()) begin
            AXIS_IN2_TVALID = 1'b1;
            AXIS_IN2_TDATA  = src2[i2].data;
            AXIS_IN2_TKEEP  = src2[i2].keep;
            AXIS_IN2_TLAST  = src2[i2].last;
        end else begin
            AXIS_IN2_TVALID = 1'b0;
            AXIS_IN2_TDATA  = '0;
            AXIS_IN2_TKEEP  = '0;
            AXIS_IN2_TLAST  = 1'b0;
        end
    endtask

    // One clock: sample handshakes on the falling edge, advance sources just after the rising edge.
    task automatic tick();
        bit    f1, f2;
        beat_t ob;
        @(negedge clk);
        f1 = AXIS_IN1_TVALID && AXIS_IN1_TREADY;
        f2 = AXIS_IN2_TVALID && AXIS_IN2_TREADY;
        ob.data = AXIS_OUT_TDATA;
        ob.keep = AXIS_OUT_TKEEP;
        ob.last = AXIS_OUT_TLAST;
        samp_in2_ready = AXIS_IN2_TREADY;
        samp_ov = AXIS_OUT_TVALID;
        if (rst_chk) begin
            check_val("reset_in1_tready", 64'(AXIS_IN1_TREADY), 64'd0);
            check_val("reset_in2_tready", 64'(AXIS_IN2_TREADY), 64'd0);
            check_val("reset_out_tvalid", 64'(AXIS_OUT_TVALID), 64'd0);
            check_val("reset_out_tdata_nonzero", 64'(AXIS_OUT_TDATA != '0), 64'd0);
            check_val("reset_out_tkeep", 64'(AXIS_OUT_TKEEP), 64'd0);
            check_val("reset_out_tlast", 64'(AXIS_OUT_TLAST), 64'd0);
            check_val("reset_sel", 64'(sel), 64'd0);
            check_val("reset_pkt_count", 64'(pkt_count), 64'd0);
            rst_chk = 1'b0;
        end
        if (prev_stall && !last_edge_rst) begin
            check_val("stall_hold_tvalid", 64'(AXIS_OUT_TVALID), 64'd1);
            check_beat("stall_hold_beat", ob, prev_beat);
        end
        prev_stall = AXIS_OUT_TVALID && !AXIS_OUT_TREADY;
        prev_beat = ob;
        if (AXIS_OUT_TVALID && AXIS_OUT_TREADY) begin
            out_q.push_back(ob);
            out_cyc.push_back(cycle);
        end
        if (f1 && AXIS_IN1_TLAST) hs1_last_cyc = cycle;
        if (f2 && hs2_first_cyc < 0) hs2_first_cyc = cycle;
        @(posedge clk);
        last_edge_rst = !resetn;
        #1;
        cycle++;
        if (f1) i1++;
        if (f2) i2++;
        if (pp_switch_beat >= 0 && i1 == pp_switch_beat) begin
            PP_GROUP = pp_switch_val;
            pp_switch_beat = -1;
        end
        AXIS_OUT_TREADY = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        drive_inputs();
    endtask

    task automatic add_pkt(input int path, input int nb, input logic [KW-1:0] last_keep, input bit rand_keep);
        for (int b = 0; b < nb; b++) begin
            beat_t bt;
            for (int w = 0; w < DW / 32; w++) bt.data[w*32 +: 32] = $urandom();
            bt.data[31:0] = {4'(path), 12'(pkt_id), 16'(b)};
            bt.keep = '1;
            bt.last = (b == nb - 1);
            if (bt.last) bt.keep = rand_keep ? KW'({$urandom(), $urandom()}) : last_keep;
            if (path == 1) src1.push_back(bt);
            else           src2.push_back(bt);
        end
        pkt_id++;
    endtask

    // Reference: whole packets taken in groups, alternating paths, stopping when a path runs dry.
    task automatic build_expected(input int g_first, input int g_rest);
        int ia = 0;
        int ib = 0;
        int g = 0;
        bit done = 0;
        exp_q.delete();
        while (!done) begin
            int lim = (g == 0) ? g_first : g_rest;
            if (lim == 0) lim = 1;
            for (int p = 0; p < lim && !done; p++) begin
                if (g % 2 == 0) begin
                    if (ia >= src1.size()) done = 1;
                    else do begin exp_q.push_back(src1[ia]); ia++; end while (!src1[ia-1].last);
                end else begin
                    if (ib >= src2.size()) done = 1;
                    else do begin exp_q.push_back(src2[ib]); ib++; end while (!src2[ib-1].last);
                end
            end
            g++;
        end
    endtask

    task automatic run_stream(input string name, input int max_cycles);
        int n = 0;
        int npk = 0;
        while (out_q.size() < exp_q.size() && n < max_cycles) begin
            tick();
            n++;
        end
        check_val({name, "_completed_in_budget"}, 64'(out_q.size() >= exp_q.size()), 64'd1);
        repeat (6) tick();
        check_val({name, "_beat_count"}, 64'(out_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < out_q.size(); k++)
            check_beat($sformatf("%s_beat%0d", name, k), out_q[k], exp_q[k]);
        foreach (exp_q[k]) if (exp_q[k].last) npk++;
        check_val({name, "_pkt_count"}, 64'(pkt_count), 64'(npk));
    endtask

    task automatic reset_dut(input logic [31:0] pp);
        PP_GROUP = pp;
        resetn = 1'b0;
        rdy_rand = 1'b0;
        p1_en = 1'b1;
        repeat (3) tick();
        resetn = 1'b1;
        i1 = 0;
        i2 = 0;
        out_q.delete();
        out_cyc.delete();
        hs1_last_cyc = -1;
        hs2_first_cyc = -1;
        cycle = 0;
        pp_switch_beat = -1;
        drive_inputs();
    endtask

    task automatic applyStimulus();
        // Cycle table, PP_GROUP=1, single-beat packets; expected columns are the outputs seen that cycle.
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1,  1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1,  1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1,  1'b0, 1'b1, 1'b1, 1'b1, 32'd1};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0, 32'd2};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 1'b1, 32'd3};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1,  1'b0, 1'b0, 1'b1, 1'b1, 32'd3};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1,  1'b0, 1'b1, 1'b1, 1'b1, 32'd3};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1,  1'b1, 1'b0, 1'b1, 1'b0, 32'd4};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0, 32'd4};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0, 32'd4};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1,  1'b0, 1'b0, 1'b0, 1'b0, 32'd0};

        PP_GROUP = 32'd1;
        resetn = 1'b0;
        AXIS_IN1_TDATA = DW'(32'h1111);
        AXIS_IN2_TDATA = DW'(32'h2222);
        AXIS_IN1_TKEEP = '1;
        AXIS_IN2_TKEEP = '1;
        AXIS_IN1_TLAST = 1'b1;
        AXIS_IN2_TLAST = 1'b1;
        AXIS_IN1_TVALID = 1'b0;
        AXIS_IN2_TVALID = 1'b0;
        AXIS_OUT_TREADY = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int r = 0; r < 12; r++) begin
            resetn = tbl[r].rstn;
            AXIS_IN1_TVALID = tbl[r].v1;
            AXIS_IN2_TVALID = tbl[r].v2;
            AXIS_OUT_TREADY = tbl[r].ordy;
            @(negedge clk);
            check_val($sformatf("tbl%0d_in1_tready", r), 64'(AXIS_IN1_TREADY), 64'(tbl[r].e_r1));
            check_val($sformatf("tbl%0d_in2_tready", r), 64'(AXIS_IN2_TREADY), 64'(tbl[r].e_r2));
            check_val($sformatf("tbl%0d_out_tvalid", r), 64'(AXIS_OUT_TVALID), 64'(tbl[r].e_ov));
            check_val($sformatf("tbl%0d_sel", r), 64'(sel), 64'(tbl[r].e_sel));
            check_val($sformatf("tbl%0d_pkt_count", r), 64'(pkt_count), 64'(tbl[r].e_pc));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput();
        int n;
        // Groups of two, 3-beat packets, no backpressure: 24 back-to-back beats.
        src1.delete(); src2.delete(); pkt_id = 0;
        for (int p = 0; p < 4; p++) add_pkt(1, 3, '0, 1'b1);
        for (int p = 0; p < 4; p++) add_pkt(2, 3, '0, 1'b1);
        reset_dut(32'd2);
        build_expected(2, 2);
        run_stream("grp2", 200);
        if (out_cyc.size() >= 24) check_val("grp2_no_bubbles_span", 64'(out_cyc[23] - out_cyc[0]), 64'd23);
        else check_val("grp2_output_beats_seen", 64'(out_cyc.size()), 64'd24);

        // Path 2 waits while path 1 idles, then follows on the very next cycle.
        src1.delete(); src2.delete();
        add_pkt(1, 2, '1, 1'b0);
        add_pkt(2, 2, '1, 1'b0);
        add_pkt(2, 2, '1, 1'b0);
        reset_dut(32'd1);
        p1_en = 1'b0;
        drive_inputs();
        for (int c = 0; c < 10; c++) begin
            tick();
            check_val($sformatf("idle_p1_c%0d_in2_tready", c), 64'(samp_in2_ready), 64'd0);
            check_val($sformatf("idle_p1_c%0d_out_tvalid", c), 64'(samp_ov), 64'd0);
        end
        p1_en = 1'b1;
        drive_inputs();
        build_expected(1, 1);
        run_stream("wait_p1", 100);
        check_val("wait_p1_switch_gap", 64'(hs2_first_cyc - hs1_last_cyc), 64'd1);

        // PP_GROUP=0 alternates every packet.
        src1.delete(); src2.delete();
        for (int p = 0; p < 3; p++) add_pkt(1, $urandom_range(1, 3), '0, 1'b1);
        for (int p = 0; p < 3; p++) add_pkt(2, $urandom_range(1, 3), '0, 1'b1);
        reset_dut(32'd0);
        build_expected(1, 1);
        run_stream("grp0", 200);

        // Random backpressure, groups of three, last-beat TKEEP of 0xFF.
        src1.delete(); src2.delete();
        for (int p = 0; p < 40; p++) add_pkt(1, $urandom_range(1, 4), KW'(64'hFF), 1'b0);
        for (int p = 0; p < 40; p++) add_pkt(2, $urandom_range(1, 4), KW'(64'hFF), 1'b0);
        reset_dut(32'd3);
        rdy_rand = 1'b1;
        build_expected(3, 3);
        run_stream("rand_bp", 3000);
        rdy_rand = 1'b0;

        // PP_GROUP 2 -> 4 during the second packet of the first group.
        src1.delete(); src2.delete();
        for (int p = 0; p < 6; p++) add_pkt(1, 3, '0, 1'b1);
        for (int p = 0; p < 6; p++) add_pkt(2, 3, '0, 1'b1);
        reset_dut(32'd2);
        pp_switch_beat = 4;
        pp_switch_val = 32'd4;
        build_expected(2, 4);
        run_stream("grp_change", 300);

        // One-cycle reset in the middle of a path-2 packet.
        src1.delete(); src2.delete();
        add_pkt(1, 2, '1, 1'b0);
        add_pkt(2, 4, '1, 1'b0);
        reset_dut(32'd1);
        n = 0;
        while (i2 < 2 && n < 50) begin
            tick();
            n++;
        end
        check_val("midpkt_reached_path2_beats", 64'(i2 >= 2), 64'd1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        src1.delete(); src2.delete();
        add_pkt(1, 2, '1, 1'b0);
        add_pkt(1, 2, '1, 1'b0);
        add_pkt(2, 2, '1, 1'b0);
        add_pkt(2, 2, '1, 1'b0);
        i1 = 0;
        i2 = 0;
        out_q.delete();
        out_cyc.delete();
        rst_chk = 1'b1;
        drive_inputs();
        build_expected(1, 1);
        run_stream("post_reset", 100);
        if (out_q.size() > 0) check_val("post_reset_first_path", 64'(out_q[0].data[31:28]), 64'd1);
        else check_val("post_reset_any_output", 64'(out_q.size()), 64'd1);
    endtask

    initial begin
        i1 = 0; i2 = 0; cycle = 0; pkt_id = 0;
        p1_en = 1'b1; rdy_rand = 1'b0; rst_chk = 1'b0;
        prev_stall = 1'b0; last_edge_rst = 1'b1;
        pp_switch_beat = -1; pp_switch_val = 32'd0;
        hs1_last_cyc = -1; hs2_first_cyc = -1;
        applyStimulus();
        checkOutput();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
